front_panel: RTL and testbench
==============================

FRONT_PANEL -- requirements
Module: front_panel

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset. Ports are listed as name, direction, width, meaning.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 clear, extd_addr, addr_load, dep, exam, cont  in  1 each  raw, asynchronous, bouncing panel switches; active-high.
REQ-005 sing_step, halt  in  1 each  raw level switches; registered through a 2-flop synchronizer and not edge-detected.
REQ-006 state  in  4  current major state from the CPU state machine; encoding comes from the shared package.
REQ-007 cleard, extd_addrd, addr_loadd, depd, examd, contd  out  1 each  one-cycle command pulses.
REQ-008 triggerd  out  1  one-cycle start pulse to the state machine for a panel memory cycle.

Function
REQ-009 Each pulsed switch SHALL pass through a 2-flop synchronizer and then a rising-edge detector.
- A 0->1 transition of the synchronized level arms a pulse.
- Holding the switch high produces no further pulses.
REQ-010 A switch high for a single clock SHALL still be detected.
REQ-011 Pulse timing: an armed pulse SHALL appear on its output exactly 3 clocks after the raw input is first sampled high.
- Its width SHALL be 1 clock.
REQ-012 Gating SHALL be as follows.
- clear, addr_load, extd_addr, dep, exam pulses: emitted only while state == ST_HALT.
- cont pulse: emitted only while state == ST_HALT.
- An armed pulse outside ST_HALT is discarded, not queued.
REQ-013 Simultaneous arms SHALL produce at most one command pulse per cycle.
- Priority: clear > addr_load > extd_addr > dep > exam > cont.
- Lower-priority arms in the same cycle are discarded.
REQ-014 triggerd SHALL pulse for 1 clock on the cycle immediately after depd or examd.
- It SHALL never pulse for any other command.
REQ-015 contd SHALL be the only command the state machine uses to leave ST_HALT. The sampled sing_step and halt levels are exported unchanged; the state machine alone interprets them.
REQ-016 All outputs SHALL be registered. No combinational path SHALL exist from any input to any output.

Reset
REQ-017 While reset = 1, all outputs SHALL be 0, and all synchronizers, edge-detect history and lockout counters SHALL clear to 0.
REQ-018 A switch that is already high when reset releases SHALL NOT generate a pulse until it returns low and rises again.
- Implementation: edge history is loaded from the synchronized level on the first cycle after reset.
REQ-019 Reset asserted mid-pulse SHALL terminate the pulse in the same cycle. A pending triggerd SHALL be dropped.

Configuration
REQ-020 Macro FP_DEBOUNCE_EN, when defined, SHALL enable per-switch lockout.
- After a pulse is armed, that switch ignores further rising edges until its synchronized level has been continuously low for 32 clocks.
- Implemented as a 5-bit counter per switch; a high sample restarts the count.
REQ-021 Without FP_DEBOUNCE_EN, there SHALL be no lockout: every synchronized rising edge arms a pulse.

Structure
REQ-022 The shared package SHALL hold the 4-bit state encoding constants (including ST_HALT) and the debounce length constant FP_LOCKOUT = 32. The front_panel and the state machine both import it.
REQ-023 One sub-module, fp_switch, SHALL implement synchronizer, edge detect and optional lockout for one switch. It is instantiated six times; priority, gating and triggerd logic stay in front_panel.

Verification
REQ-024 The bench SHALL cover these scenarios, with FP_DEBOUNCE_EN defined:
- Gated load: state = ST_HALT, addr_load high 3 clocks -> exactly one addr_loadd pulse, 1 clock wide, 3 clocks after first high sample; triggerd stays 0.
- Exam: exam high 2 clocks in ST_HALT -> examd pulse, then triggerd pulse on the following clock.
- Run-state gating: state != ST_HALT, dep and cont each pulsed 1 clock -> no depd, contd or triggerd; after state returns to ST_HALT with no new edge -> still no pulse.
- Bounce and lockout: cont toggles 1,0,1,0,1 at 1-clock spacing -> one contd. Then low for 40 clocks and high again -> a second contd.
- Priority: clear and dep rise in the same clock -> cleard only; no depd, no triggerd.
- Reset: reset asserted while addr_load is held high, then released -> no addr_loadd until addr_load falls and rises again.

Source files
------------

// File: rtl/front_panel_pkg.sv
// Shared definitions for the operator front panel and the CPU state machine.
// Holds the major-state encoding, switch indices and the lockout length.
package front_panel_pkg;

  typedef logic [3:0] cpu_state_t;

  localparam cpu_state_t ST_RESET  = 4'h0;
  localparam cpu_state_t ST_FETCH  = 4'h1;
  localparam cpu_state_t ST_DECODE = 4'h2;
  localparam cpu_state_t ST_EXEC   = 4'h3;
  localparam cpu_state_t ST_MEM_RD = 4'h4;
  localparam cpu_state_t ST_MEM_WR = 4'h5;
  localparam cpu_state_t ST_PANEL  = 4'h6;
  localparam cpu_state_t ST_HALT   = 4'hF;

  localparam int FP_LOCKOUT = 32;
  localparam int FP_NUM_SW  = 6;

  // Index order is also command priority: lowest index wins.
  typedef enum logic [2:0] {
    SW_CLEAR     = 3'd0,
    SW_ADDR_LOAD = 3'd1,
    SW_EXTD_ADDR = 3'd2,
    SW_DEP       = 3'd3,
    SW_EXAM      = 3'd4,
    SW_CONT      = 3'd5
  } sw_idx_e;

  function automatic logic [FP_NUM_SW-1:0] fp_first_set(input logic [FP_NUM_SW-1:0] v);
    return v & (~v + {{(FP_NUM_SW-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/front_panel_if.sv
// Front panel bus: raw switch levels and CPU state in, command pulses and
// synchronized sing_step/halt levels out.
interface front_panel_if;
  import front_panel_pkg::*;

  logic       clear, extd_addr, addr_load, dep, exam, cont;
  logic       sing_step, halt;
  cpu_state_t state;
  logic       cleard, extd_addrd, addr_loadd, depd, examd, contd;
  logic       triggerd;
  logic       sing_stepd, haltd;

  modport slave (
    input  clear, extd_addr, addr_load, dep, exam, cont, sing_step, halt, state,
    output cleard, extd_addrd, addr_loadd, depd, examd, contd, triggerd,
           sing_stepd, haltd
  );

  modport master (
    output clear, extd_addr, addr_load, dep, exam, cont, sing_step, halt, state,
    input  cleard, extd_addrd, addr_loadd, depd, examd, contd, triggerd,
           sing_stepd, haltd
  );
endinterface

// File: rtl/front_panel_switch.sv
// fp_switch: 2-flop synchronizer, rising-edge detect and registered arm for one
// panel switch. Optional lockout enabled by macro FP_DEBOUNCE_EN.
module fp_switch
  import front_panel_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_arm
);
  logic [1:0] r_sync;
  logic       r_hist;
  logic [1:0] r_warm;
  logic       r_arm;
  logic       w_rise;
  logic       w_take;

  // Edges are ignored until the synchronizer has refilled after reset, so a
  // switch already high at release is absorbed into the history.
  assign w_rise = r_sync[1] & ~r_hist & (r_warm == 2'd3);

`ifdef FP_DEBOUNCE_EN
  logic       r_locked;
  logic [4:0] r_low_cnt;

  assign w_take = w_rise & ~r_locked;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_locked  <= 1'b0;
      r_low_cnt <= '0;
    end else if (w_take) begin
      r_locked  <= 1'b1;
      r_low_cnt <= '0;
    end else if (r_locked) begin
      if (r_sync[1]) begin
        r_low_cnt <= '0;
      end else if (r_low_cnt == 5'(FP_LOCKOUT - 1)) begin
        r_locked  <= 1'b0;
        r_low_cnt <= '0;
      end else begin
        r_low_cnt <= r_low_cnt + 5'd1;
      end
    end
  end
`else
  assign w_take = w_rise;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_warm <= '0;
      r_arm  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      r_hist <= r_sync[1];
      if (r_warm != 2'd3) r_warm <= r_warm + 2'd1;
      r_arm  <= w_take;
    end
  end

  assign o_arm = r_arm;

endmodule

// File: rtl/front_panel.sv
// Front panel command generator: six debounced switch pulses, priority and
// ST_HALT gating, triggerd after dep/exam. Lockout via macro FP_DEBOUNCE_EN.
module front_panel
  import front_panel_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  front_panel_if.slave bus
);
  logic [FP_NUM_SW-1:0] w_raw;
  logic [FP_NUM_SW-1:0] w_arm;
  logic [FP_NUM_SW-1:0] w_grant;
  logic [FP_NUM_SW-1:0] r_cmd;
  logic                 r_trig;
  logic [1:0]           r_ss_sync;
  logic [1:0]           r_halt_sync;

  assign w_raw = {bus.cont, bus.exam, bus.dep, bus.extd_addr, bus.addr_load, bus.clear};

  for (genvar gi = 0; gi < FP_NUM_SW; gi++) begin : g_sw
    fp_switch u_sw (
      .i_clk   (clk),
      .i_reset (reset),
      .i_raw   (w_raw[gi]),
      .o_arm   (w_arm[gi])
    );
  end

  // Arms outside ST_HALT and losing lower-priority arms are simply dropped.
  assign w_grant = (bus.state == ST_HALT) ? fp_first_set(w_arm) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd       <= '0;
      r_trig      <= 1'b0;
      r_ss_sync   <= '0;
      r_halt_sync <= '0;
    end else begin
      r_cmd       <= w_grant;
      r_trig      <= r_cmd[SW_DEP] | r_cmd[SW_EXAM];
      r_ss_sync   <= {r_ss_sync[0], bus.sing_step};
      r_halt_sync <= {r_halt_sync[0], bus.halt};
    end
  end

  assign bus.cleard     = r_cmd[SW_CLEAR];
  assign bus.addr_loadd = r_cmd[SW_ADDR_LOAD];
  assign bus.extd_addrd = r_cmd[SW_EXTD_ADDR];
  assign bus.depd       = r_cmd[SW_DEP];
  assign bus.examd      = r_cmd[SW_EXAM];
  assign bus.contd      = r_cmd[SW_CONT];
  assign bus.triggerd   = r_trig;
  assign bus.sing_stepd = r_ss_sync[1];
  assign bus.haltd      = r_halt_sync[1];

endmodule

// File: tb/tb_front_panel.sv
// Bench for front_panel: directed panel scenarios plus random switching,
// checked every cycle against a history-based reference model.
module tb_front_panel;
  import front_panel_pkg::*;

  localparam int MAXC = 4096;
  localparam int NSW  = FP_NUM_SW;
`ifdef FP_DEBOUNCE_EN
  localparam int BOUNCE_EXP = 1;
`else
  localparam int BOUNCE_EXP = 3;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NSW-1:0] sw = '0;
  logic           ss = 1'b0;
  logic           hl = 1'b0;
  cpu_state_t     st = ST_HALT;

  always #5 clk = ~clk;

  front_panel_if fp ();

  assign fp.clear     = sw[SW_CLEAR];
  assign fp.addr_load = sw[SW_ADDR_LOAD];
  assign fp.extd_addr = sw[SW_EXTD_ADDR];
  assign fp.dep       = sw[SW_DEP];
  assign fp.exam      = sw[SW_EXAM];
  assign fp.cont      = sw[SW_CONT];
  assign fp.sing_step = ss;
  assign fp.halt      = hl;
  assign fp.state     = st;

  front_panel dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fp)
  );

  // Input history per clock edge (edge 1 is the first rising edge).
  bit             raw_h [NSW][MAXC];
  bit             rst_h [MAXC];
  bit             ss_h  [MAXC];
  bit             hl_h  [MAXC];
  cpu_state_t     st_h  [MAXC];
  bit             arm_m [NSW][MAXC];
  bit [NSW-1:0]   out_m [MAXC];
  bit             trig_m[MAXC];
  int             last_arm [NSW];
  int             cyc = 0;

  int n_checks = 0;
  int n_pass   = 0;

  int pcnt [NSW];
  int first_seen [NSW];
  int tcnt;
  int first_trig;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  function automatic bit raw_at(input int s, input int e);
    return (e < 1) ? 1'b0 : raw_h[s][e];
  endfunction

  function automatic bit rst_at(input int e);
    return (e < 1) ? 1'b1 : rst_h[e];
  endfunction

  // An edge seen by the synchronizer counts only if no reset touched the
  // samples it depends on.
  function automatic bit quiet(input int e);
    for (int k = e - 3; k <= e; k++) if (rst_at(k)) return 1'b0;
    return 1'b1;
  endfunction

  // Since the last accepted arm, has the synchronized level (raw delayed two
  // edges) been low for FP_LOCKOUT consecutive samples?
  function automatic bit lockout_clear(input int s, input int e);
    int run;
    if (last_arm[s] < 0) return 1'b1;
    run = 0;
    for (int k = last_arm[s] + 1; k < e; k++) begin
      if (raw_at(s, k - 2)) run = 0;
      else run++;
      if (run >= FP_LOCKOUT) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input int e);
    bit cand;
    bit acc;
    bit found;
    for (int s = 0; s < NSW; s++) begin
      if (rst_at(e)) begin
        arm_m[s][e] = 1'b0;
        last_arm[s] = -1;
      end else begin
        cand = quiet(e) && raw_at(s, e - 2) && !raw_at(s, e - 3);
        acc  = cand;
`ifdef FP_DEBOUNCE_EN
        acc  = cand && lockout_clear(s, e);
`endif
        arm_m[s][e] = acc;
        if (acc) last_arm[s] = e;
      end
    end
    out_m[e] = '0;
    found = 1'b0;
    if (!rst_at(e) && st_h[e] == ST_HALT) begin
      for (int s = 0; s < NSW; s++) begin
        if (!found && arm_m[s][e-1]) begin
          out_m[e][s] = 1'b1;
          found = 1'b1;
        end
      end
    end
    trig_m[e] = !rst_at(e) && (out_m[e-1][SW_DEP] || out_m[e-1][SW_EXAM]);
  endtask

  function automatic logic [NSW-1:0] got_cmd();
    return {fp.contd, fp.examd, fp.depd, fp.extd_addrd, fp.addr_loadd, fp.cleard};
  endfunction

  task automatic check_edge(input int e);
    logic [NSW-1:0] g;
    logic [1:0]     exp_lvl;
    g = got_cmd();
    exp_lvl = (!rst_at(e) && !rst_at(e - 1)) ? {ss_h[e-1], hl_h[e-1]} : 2'b00;
    chk("cmd", 32'(g), 32'(out_m[e]));
    chk("trig", 32'(fp.triggerd), 32'(trig_m[e]));
    chk("levels", 32'({fp.sing_stepd, fp.haltd}), 32'(exp_lvl));
    for (int s = 0; s < NSW; s++) begin
      if (g[s]) begin
        pcnt[s]++;
        if (first_seen[s] < 0) first_seen[s] = e;
      end
    end
    if (fp.triggerd) begin
      tcnt++;
      if (first_trig < 0) first_trig = e;
    end
  endtask

  task automatic step();
    if (cyc >= MAXC - 2) begin
      $display("FAIL history overflow at edge %0d", cyc);
      $fatal(1, "history overflow");
    end
    cyc++;
    for (int s = 0; s < NSW; s++) raw_h[s][cyc] = sw[s];
    rst_h[cyc] = reset;
    ss_h[cyc]  = ss;
    hl_h[cyc]  = hl;
    st_h[cyc]  = st;
    @(posedge clk);
    model_edge(cyc);
    @(negedge clk);
    check_edge(cyc);
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic idle(input int n);
    sw = '0;
    hold(n);
  endtask

  task automatic clr_stats();
    for (int s = 0; s < NSW; s++) begin
      pcnt[s] = 0;
      first_seen[s] = -1;
    end
    tcnt = 0;
    first_trig = -1;
  endtask

  initial begin
    int e0;
    for (int s = 0; s < NSW; s++) last_arm[s] = -1;
    out_m[0]  = '0;
    trig_m[0] = 1'b0;
    clr_stats();

    reset = 1'b1;
    hold(4);
    chk("reset_outputs", 32'({got_cmd(), fp.triggerd, fp.sing_stepd, fp.haltd}), 32'd0);
    reset = 1'b0;
    idle(40);

    // Gated load: three clocks high gives exactly one pulse, 3 clocks late.
    clr_stats();
    e0 = cyc + 1;
    sw[SW_ADDR_LOAD] = 1'b1;
    hold(3);
    idle(10);
    chk("load_count", 32'(pcnt[SW_ADDR_LOAD]), 32'd1);
    chk("load_latency", 32'(first_seen[SW_ADDR_LOAD] - e0), 32'd3);
    chk("load_trig", 32'(tcnt), 32'd0);
    idle(40);

    // Exam followed by triggerd one clock later.
    clr_stats();
    sw[SW_EXAM] = 1'b1;
    hold(2);
    idle(10);
    chk("exam_count", 32'(pcnt[SW_EXAM]), 32'd1);
    chk("exam_trig_count", 32'(tcnt), 32'd1);
    chk("exam_trig_gap", 32'(first_trig - first_seen[SW_EXAM]), 32'd1);
    idle(40);

    // Run-state gating: edges outside ST_HALT are dropped, not queued.
    clr_stats();
    st = ST_EXEC;
    sw[SW_DEP] = 1'b1;
    hold(1);
    idle(3);
    sw[SW_CONT] = 1'b1;
    hold(1);
    idle(8);
    st = ST_HALT;
    hold(10);
    chk("run_dep", 32'(pcnt[SW_DEP]), 32'd0);
    chk("run_cont", 32'(pcnt[SW_CONT]), 32'd0);
    chk("run_trig", 32'(tcnt), 32'd0);
    idle(40);

    // Bouncing cont, then a clean re-press after 40 low clocks.
    clr_stats();
    sw[SW_CONT] = 1'b1; hold(1);
    sw[SW_CONT] = 1'b0; hold(1);
    sw[SW_CONT] = 1'b1; hold(1);
    sw[SW_CONT] = 1'b0; hold(1);
    sw[SW_CONT] = 1'b1; hold(1);
    idle(40);
    chk("bounce_count", 32'(pcnt[SW_CONT]), 32'(BOUNCE_EXP));
    clr_stats();
    sw[SW_CONT] = 1'b1;
    hold(2);
    idle(8);
    chk("repress_count", 32'(pcnt[SW_CONT]), 32'd1);
    idle(40);

    // Priority: clear beats dep, and no trigger follows.
    clr_stats();
    sw[SW_CLEAR] = 1'b1;
    sw[SW_DEP]   = 1'b1;
    hold(2);
    idle(10);
    chk("prio_clear", 32'(pcnt[SW_CLEAR]), 32'd1);
    chk("prio_dep", 32'(pcnt[SW_DEP]), 32'd0);
    chk("prio_trig", 32'(tcnt), 32'd0);
    idle(40);

    // Switch held through reset release must not pulse until re-pressed.
    clr_stats();
    reset = 1'b1;
    sw[SW_ADDR_LOAD] = 1'b1;
    hold(3);
    reset = 1'b0;
    hold(12);
    chk("held_thru_reset", 32'(pcnt[SW_ADDR_LOAD]), 32'd0);
    idle(3);
    sw[SW_ADDR_LOAD] = 1'b1;
    hold(2);
    idle(8);
    chk("rearm_after_reset", 32'(pcnt[SW_ADDR_LOAD]), 32'd1);
    idle(40);

    // Reset right after depd drops the pending trigger.
    clr_stats();
    sw[SW_DEP] = 1'b1;
    hold(1);
    idle(3);
    reset = 1'b1;
    hold(2);
    reset = 1'b0;
    idle(10);
    chk("trig_dropped_dep", 32'(pcnt[SW_DEP]), 32'd1);
    chk("trig_dropped", 32'(tcnt), 32'd0);
    idle(40);

    // Reset on the pulse edge itself kills the pulse.
    clr_stats();
    sw[SW_EXAM] = 1'b1;
    hold(1);
    idle(2);
    reset = 1'b1;
    hold(2);
    reset = 1'b0;
    idle(10);
    chk("pulse_killed", 32'(pcnt[SW_EXAM]), 32'd0);
    chk("pulse_killed_trig", 32'(tcnt), 32'd0);
    idle(40);

    // Random switching: busy phase, then sparse phase so lockouts expire.
    for (int i = 0; i < 1600; i++) begin
      int rate;
      rate = (i < 700) ? 7 : 59;
      for (int s = 0; s < NSW; s++)
        if ($urandom_range(rate) == 0) sw[s] = ~sw[s];
      if ($urandom_range(7) == 0) ss = ~ss;
      if ($urandom_range(7) == 0) hl = ~hl;
      st = ($urandom_range(3) == 0) ? ST_EXEC : ST_HALT;
      reset = ($urandom_range(149) == 0);
      step();
    end
    reset = 1'b0;
    idle(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
